// File: rtl/ip_update_pkg.sv
// ip_update_pkg: arbitration mode encodings and pointer sizing shared by the arbiter files.
package ip_update_pkg;
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR = 1;
  function automatic int ptr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_select.sv
// rr_select: one-hot winner, lowest index at or after p (cyclic) in round robin, lowest index otherwise.
module rr_select
  import ip_update_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PW = ptr_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PW-1:0]       p,
  input  logic                mode,
  output logic [CHANNELS-1:0] winner
);
  logic [CHANNELS-1:0] upper, pick;
  // Requests at or above p win first; if none, wrap around to the full request set.
  always_comb begin
    upper = mode ? req & ~((CHANNELS'(1) << p) - CHANNELS'(1)) : req;
    pick = |upper ? upper : req;
    winner = pick & (~pick + CHANNELS'(1));
  end
endmodule

// File: rtl/ip_update_arbiter.sv
// ip_update_arbiter: arbitrates per-channel writes to a shared instruction pointer and counts disagreeing updates.
module ip_update_arbiter
  import ip_update_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH = 2,
  parameter int MODE = MODE_FIXED,
  parameter int CWIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_IP = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] value,
  output logic [WIDTH-1:0]          ip,
  output logic [CHANNELS-1:0]       grant,
  output logic                      updated,
  output logic                      conflict,
  output logic [CWIDTH-1:0]         conflicts
);
  localparam int PW = ptr_width(CHANNELS);
  logic [PW-1:0] p, widx, next_p;
  logic [CHANNELS-1:0] winner;
  logic [WIDTH-1:0] wval;
  logic diff;
  rr_select #(.CHANNELS(CHANNELS), .PW(PW)) u_sel (
    .req(req),
    .p(p),
    .mode(MODE == MODE_RR),
    .winner(winner)
  );
  // A conflict is any requester whose value differs from the winner's.
  always_comb begin
    widx = '0;
    wval = '0;
    diff = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (winner[i]) begin
        widx = PW'(i);
        wval = value[i*WIDTH +: WIDTH];
      end
    for (int i = 0; i < CHANNELS; i++)
      if (req[i] && value[i*WIDTH +: WIDTH] != wval) diff = 1'b1;
    next_p = (widx == PW'(CHANNELS - 1)) ? '0 : widx + PW'(1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ip <= RESET_IP;
      grant <= '0;
      updated <= 1'b0;
      conflict <= 1'b0;
      conflicts <= '0;
      p <= '0;
    end else begin
      grant <= winner;
      updated <= |req;
      conflict <= diff;
      if (|req) ip <= wval;
      if (|req && MODE == MODE_RR) p <= next_p;
      if (diff && conflicts != '1) conflicts <= conflicts + CWIDTH'(1);
    end
endmodule

// File: doc/ip_update_arbiter.md
IP_UPDATE_ARBITER -- requirements
Module: ip_update_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of update channels, minimum 1.
REQ-002 SHALL have parameter WIDTH, default 2: width of the shared instruction-pointer register.
REQ-003 SHALL have parameter MODE, default 0: 0 = fixed priority (lowest index wins); 1 = round robin.
REQ-004 SHALL have parameter CWIDTH, default 8: width of the conflict counter.
REQ-005 SHALL have parameter RESET_IP, default 0: value loaded into ip on reset.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req, input, CHANNELS bits: per-channel update request.
REQ-009 SHALL have port value, input, CHANNELS*WIDTH bits: channel i proposed ip at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port ip, output, WIDTH bits: the shared register.
REQ-011 SHALL have port grant, output, CHANNELS bits: one-hot winner of the last update, or zero.
REQ-012 SHALL have port updated, output, 1 bit: ip was written at the last posedge.
REQ-013 SHALL have port conflict, output, 1 bit: the last update had disagreeing requesters.
REQ-014 SHALL have port conflicts, output, CWIDTH bits: saturating count of conflicts.

Function
REQ-015 SHALL, on a posedge with any req bit set, load ip with the winner's value, set grant to the winner's one-hot and set updated=1; latency is one cycle.
REQ-016 SHALL, on a posedge with req=0, hold ip and clear grant, updated and conflict.
REQ-017 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-018 SHALL, in MODE 0, select the lowest-index requesting channel.
REQ-019 SHALL, in MODE 1, keep a pointer p (reset 0) and select the first requesting index at or after p, scanning cyclically.
REQ-020 SHALL, in MODE 1, set p to (winner+1) mod CHANNELS after each grant; p holds when there is no request.
REQ-021 SHALL always grant a sole requester, regardless of p.
REQ-022 SHALL set conflict=1 when two or more channels request with values that are not all equal; it is set in the same cycle as the grant.
REQ-023 SHALL, when several requesters present identical values, set conflict=0 while still arbitrating and advancing p normally.
REQ-024 SHALL increment conflicts on each conflict, saturating at all-ones; it never wraps.
REQ-025 SHALL, with CHANNELS=1, never assert conflict and keep p constant at 0.

Reset
REQ-026 SHALL, on assertion of reset, immediately and without waiting for clock, set ip=RESET_IP, grant=0, updated=0, conflict=0, conflicts=0 and p=0.
REQ-027 SHALL discard any request present while reset is high; the first update occurs on the first posedge after reset deasserts.

Structure
REQ-028 SHALL place the MODE encoding constants (MODE_FIXED=0, MODE_RR=1) in shared package ip_update_pkg.
REQ-029 SHALL implement winner selection in sub-module rr_select (inputs req, p, mode; output one-hot winner), instantiated once.

Verification
REQ-030 SHALL cover: MODE 0, CHANNELS=2, req=11, ch0=1, ch1=3 -> ip=1, grant=01, updated=1, conflict=1, conflicts=1.
REQ-031 SHALL cover: MODE 1, same stimulus held 3 cycles -> ip 1,3,1; grant 01,10,01; conflicts=3.
REQ-032 SHALL cover: req=11 with both values=2 -> ip=2, conflict=0, conflicts unchanged.
REQ-033 SHALL cover: CWIDTH=2, 5 consecutive conflicts -> conflicts=3 and holds at 3.
REQ-034 SHALL cover: MODE 1 with ip=3 and p=1, reset asserted mid-cycle -> ip=0 before the next edge; after release, req=11 grants 01.
REQ-035 SHALL cover: CHANNELS=4, MODE 1, req=1010 held -> grant 0010,1000,0010; then req=0 -> grant=0, updated=0, ip held.
